// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-mouse command transmitter: sends 0xF4 (enable) or 0xF5 (disable)
// with odd parity, then checks the device acknowledge; lines are driven as pull-low enables.
module ps2_host_transmitter #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter logic [7:0]  CMD_ENABLE     = 8'hF4,
    parameter logic [7:0]  CMD_DISABLE    = 8'hF5
) (
    input  logic iClk,
    input  logic iResetn,
    input  logic iStartTransmission,
    input  logic iEnableMouse,
    input  logic iPs2Clk,
    input  logic iPs2Dat,
    output logic oPs2ClkLow,
    output logic oPs2DatLow,
    output logic oBusy,
    output logic oDone,
    output logic oError
);
    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_ACK,
        S_WAIT_IDLE,
        S_FINISH,
        S_FAIL
    } state_t;

    state_t           state_q;
    logic             clk_meta_q, clk_sync_q, clk_prev_q;
    logic             dat_meta_q, dat_sync_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [INH_W-1:0] inh_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [3:0]       edge_cnt_q;
    logic             clk_low_q, dat_low_q, busy_q, done_q, error_q;

    logic [7:0] cmd_d;
    logic       ps2_fall, tmo_run, frame_edge, tmo_expired, ack_missing, fail_d;

    assign cmd_d       = iEnableMouse ? CMD_ENABLE : CMD_DISABLE;
    assign ps2_fall    = clk_prev_q & ~clk_sync_q;
    assign tmo_run     = state_q inside {S_START, S_DATA, S_PARITY, S_STOP, S_ACK, S_WAIT_IDLE};
    assign frame_edge  = ps2_fall && (state_q inside {S_START, S_DATA, S_PARITY, S_STOP, S_ACK});
    // A falling edge in the same cycle as expiry counts as progress, not a timeout.
    assign tmo_expired = tmo_run && !ps2_fall && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign ack_missing = (state_q == S_ACK) && ps2_fall && dat_sync_q;
    assign fail_d      = tmo_expired | ack_missing;

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            state_q    <= S_IDLE;
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            inh_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            edge_cnt_q <= '0;
            clk_low_q  <= 1'b0;
            dat_low_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            clk_meta_q <= iPs2Clk;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= iPs2Dat;
            dat_sync_q <= dat_meta_q;
            done_q     <= 1'b0;

            if (tmo_run) begin
                tmo_cnt_q <= ps2_fall ? '0 : tmo_cnt_q + TMO_W'(1);
            end
            if (frame_edge) begin
                edge_cnt_q <= edge_cnt_q + 4'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (iStartTransmission) begin
                        shift_q   <= cmd_d;
                        parity_q  <= ~^cmd_d;
                        error_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        clk_low_q <= 1'b1;
                        inh_cnt_q <= '0;
                        state_q   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                        clk_low_q  <= 1'b0;
                        dat_low_q  <= 1'b1;
                        tmo_cnt_q  <= '0;
                        edge_cnt_q <= '0;
                        state_q    <= S_START;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + INH_W'(1);
                    end
                end
                S_START, S_DATA: begin
                    // Falling edges #1..#8 each present the next data bit, LSB first.
                    if (ps2_fall) begin
                        dat_low_q <= ~shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        state_q   <= (edge_cnt_q == 4'd7) ? S_PARITY : S_DATA;
                    end
                end
                S_PARITY: begin
                    if (ps2_fall) begin
                        dat_low_q <= ~parity_q;
                        state_q   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (ps2_fall) begin
                        dat_low_q <= 1'b0;
                        state_q   <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (ps2_fall && !dat_sync_q) begin
                        state_q <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (clk_sync_q && dat_sync_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH, S_FAIL: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (fail_d) begin
                clk_low_q <= 1'b0;
                dat_low_q <= 1'b0;
                error_q   <= 1'b1;
                done_q    <= 1'b1;
                state_q   <= S_FAIL;
            end
        end
    end

    assign oPs2ClkLow = clk_low_q;
    assign oPs2DatLow = dat_low_q;
    assign oBusy      = busy_q;
    assign oDone      = done_q;
    assign oError     = error_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: a behavioural PS/2 mouse clocks frames out of the host,
// and a reference built from the command byte, odd parity and ack choice predicts each result.
module tb_ps2_host_transmitter;
    localparam int INH  = 10;
    localparam int TMO  = 200;
    localparam int HALF = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_tx = 1'b0;
    logic enable_mouse = 1'b0;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    logic clk_low, dat_low, busy, done, err;
    logic ps2_clk, ps2_dat;

    assign ps2_clk = ~(clk_low | dev_clk_low);
    assign ps2_dat = ~(dat_low | dev_dat_low);

    always #5 clk = ~clk;

    ps2_host_transmitter #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .CMD_ENABLE    (8'hF4),
        .CMD_DISABLE   (8'hF5)
    ) dut (
        .iClk              (clk),
        .iResetn           (rst_n),
        .iStartTransmission(start_tx),
        .iEnableMouse      (enable_mouse),
        .iPs2Clk           (ps2_clk),
        .iPs2Dat           (ps2_dat),
        .oPs2ClkLow        (clk_low),
        .oPs2DatLow        (dat_low),
        .oBusy             (busy),
        .oDone             (done),
        .oError            (err)
    );

    int n_compared = 0;
    int n_mismatched = 0;
    int n_frames = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Done-pulse monitor: counts pulses and records what surrounded the most recent one.
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic done_err = 1'b0;
    logic busy_after = 1'b1;
    logic lines_after = 1'b1;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (prev_done) begin
            busy_after  = busy;
            lines_after = clk_low | dat_low;
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            done_err = err;
        end
        prev_done = done;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Device side: optional lead-in, then up to 11 clock pulses; samples line on rising edges.
    task automatic device_frame(input int lead, input int n_edges, input bit ack,
                                output logic [9:0] bits, output int fall_cyc);
        bits = '1;
        fall_cyc = cyc;
        repeat (lead) @(negedge clk);
        for (int k = 1; k <= n_edges; k++) begin
            dev_clk_low = 1'b1;
            fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            if (k <= 10) bits[k-1] = ps2_dat;
            dev_clk_low = 1'b0;
            if (k == 10 && ack) begin
                repeat (HALF / 2) @(negedge clk);
                dev_dat_low = 1'b1;
                repeat (HALF / 2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic begin_frame(input bit en_i, output int start_cyc);
        int inh_len;
        @(negedge clk);
        start_tx = 1'b1;
        enable_mouse = en_i;
        @(negedge clk);
        start_tx = 1'b0;
        enable_mouse = 1'($urandom);
        check_eq("busy_on_accept", busy, 1);
        inh_len = 0;
        while (clk_low === 1'b1 && inh_len < 1000) begin
            inh_len++;
            @(negedge clk);
        end
        check_eq("inhibit_len", inh_len, INH);
        check_eq("start_bit_dat_low", dat_low, 1);
        start_cyc = cyc;
    endtask

    task automatic run_frame(input bit en_i, input bit ack, input int n_edges, input bit disturb);
        logic [7:0] cmd;
        logic [9:0] exp_bits, got_bits;
        logic       exp_err;
        int         start_cyc, fall_cyc, d0, lead, elapsed;
        cmd      = en_i ? 8'hF4 : 8'hF5;
        exp_bits = {1'b1, ($countones(cmd) % 2 == 0) ? 1'b1 : 1'b0, cmd};
        exp_err  = (n_edges < 11) ? 1'b1 : !ack;
        d0       = done_cnt;
        lead     = $urandom_range(30, 10);
        begin_frame(en_i, start_cyc);
        if (disturb) begin
            fork
                device_frame(lead, n_edges, ack, got_bits, fall_cyc);
                begin
                    repeat (lead + 100) @(negedge clk);
                    start_tx = 1'b1;
                    enable_mouse = ~en_i;
                    repeat (5) @(negedge clk);
                    start_tx = 1'b0;
                end
            join
        end else begin
            device_frame(lead, n_edges, ack, got_bits, fall_cyc);
        end
        for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check_eq("done_pulse_count", done_cnt - d0, 1);
        check_eq("error_at_done", done_err, exp_err);
        check_eq("busy_after_done", busy_after, 0);
        check_eq("lines_released", lines_after, 0);
        if (n_edges == 11) check_eq("frame_bits", got_bits, exp_bits);
        if (n_edges == 0) begin
            elapsed = done_cyc - start_cyc;
            check_eq("silent_timeout", elapsed, TMO);
        end else if (n_edges < 11) begin
            elapsed = done_cyc - fall_cyc;
            check_eq("stall_timeout_window", (elapsed >= TMO && elapsed <= TMO + 6) ? 1 : 0, 1);
        end else begin
            elapsed = done_cyc - start_cyc;
        end
        repeat (10) @(negedge clk);
        check_eq("error_held_idle", err, exp_err);
        check_eq("idle_not_busy", busy, 0);
        n_frames++;
        $display("frame %0d: cmd=%02h edges=%0d ack=%0d disturb=%0d bits=%03h err=%0d cycles=%0d",
                 n_frames, cmd, n_edges, ack, disturb, got_bits, done_err, elapsed);
    endtask

    initial begin
        int sc, fc, sel, ne;
        logic [9:0] b;
        repeat (3) @(negedge clk);
        check_eq("reset_lines", {clk_low, dat_low}, 0);
        check_eq("reset_status", {busy, done, err}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_after_reset", {clk_low, dat_low, busy, done, err}, 0);

        run_frame(1'b1, 1'b1, 11, 1'b0);
        run_frame(1'b0, 1'b1, 11, 1'b0);
        run_frame(1'b1, 1'b0, 11, 1'b0);
        run_frame(1'b0, 1'b1, 0, 1'b0);
        run_frame(1'b1, 1'b1, 5, 1'b0);
        run_frame(1'b1, 1'b1, 11, 1'b1);
        run_frame(1'b0, 1'b1, 11, 1'b1);

        // Asynchronous reset in the middle of the data bits.
        begin_frame(1'b1, sc);
        device_frame(20, 3, 1'b1, b, fc);
        check_eq("busy_before_reset", busy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_clk_low", clk_low, 0);
        check_eq("async_reset_dat_low", dat_low, 0);
        check_eq("async_reset_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(1'b0, 1'b1, 11, 1'b0);

        for (int i = 0; i < 10; i++) begin
            sel = $urandom_range(5, 0);
            ne  = (sel == 4) ? 0 : (sel == 5) ? $urandom_range(10, 1) : 11;
            run_frame(1'($urandom), ($urandom_range(3, 0) != 0), ne, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ps2_host_transmitter.md
Name: ps2_host_transmitter

Overview:
- Host-to-mouse PS/2 command transmitter. It is the far end of the start-transmission / enable-mouse request lines driven by the drawing control path.
- On a start request it sends one command byte to the mouse: 0xF4 enables streaming, 0xF5 disables it. It then checks the mouse acknowledge bit.
- It drives the PS/2 clock and data lines open-drain through pull-low enables. The top level ties each line as "enable ? 0 : Z".

Parameters:
- INHIBIT_CYCLES, 6000: number of iClk cycles PS2 clock is held low before the start bit (120 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum iClk cycles allowed between consecutive device clock falling edges, and before the first one (15 ms at 50 MHz).
- CMD_ENABLE, 8'hF4: byte sent when iEnableMouse=1.
- CMD_DISABLE, 8'hF5: byte sent when iEnableMouse=0.

Ports:
- iClk  in  1  system clock; single clock domain.
- iResetn  in  1  asynchronous, active-low reset.
- iStartTransmission  in  1  level/pulse request; sampled in IDLE.
- iEnableMouse  in  1  selects command byte; latched together with the start request.
- iPs2Clk  in  1  raw PS2 clock line (asynchronous).
- iPs2Dat  in  1  raw PS2 data line (asynchronous).
- oPs2ClkLow  out  1  1 = pull PS2 clock low, 0 = release.
- oPs2DatLow  out  1  1 = pull PS2 data low, 0 = release.
- oBusy  out  1  high from accepted start until return to IDLE.
- oDone  out  1  one-cycle pulse at end of every transaction (success or failure).
- oError  out  1  valid with oDone; held until the next accepted start.

Behaviour:
- Reset (async, any state): state=IDLE; oPs2ClkLow=0, oPs2DatLow=0, oBusy=0, oDone=0, oError=0; counters cleared.
- Input sync: iPs2Clk and iPs2Dat each pass through a 2-flop synchronizer.
  - A falling edge is registered-previous=1 and current=0 on the synced clock.
  - Line drive updates on the cycle after edge detection.
- IDLE: if iStartTransmission=1, latch shift register = iEnableMouse ? CMD_ENABLE : CMD_DISABLE. Latch parity = ~^byte (odd parity). Clear oError, set oBusy, go to INHIBIT. Otherwise stay in IDLE.
- INHIBIT: oPs2ClkLow=1 for exactly INHIBIT_CYCLES cycles. On the last cycle assert oPs2DatLow=1 (start bit), then go to START.
- START: oPs2ClkLow=0 (released) and oPs2DatLow held at 1. Wait for falling edge #1.
- DATA: on falling edges #1..#8, drive bit i (LSB first): oPs2DatLow = ~bit.
- PARITY: falling edge #9 drives oPs2DatLow = ~parity.
- STOP: falling edge #10 sets oPs2DatLow=0 (stop bit 1, line released).
- ACK: at falling edge #11, sample synced data.
  - 0 means acknowledged: go to WAIT_IDLE.
  - 1 means no ack: go to FAIL.
- WAIT_IDLE: wait until synced clock=1 and synced data=1, then go to FINISH.
- FINISH: oDone=1 for one cycle with oError=0; oBusy drops next cycle; return to IDLE.
- FAIL: release both lines; oError=1; oDone=1 for one cycle; return to IDLE.
- Edge counter: 4 bits, 0..11; cleared on entering START.
- Timeout counter:
  - Cleared on entering START and on every detected falling edge.
  - Runs in START, DATA, PARITY, STOP, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES causes FAIL.
- Start requests while oBusy=1 are ignored; the command byte does not change mid-frame.
- A start request in the cycle oDone pulses is ignored. The next accepted start is the first IDLE cycle.
- Glitches shorter than 2 iClk cycles on iPs2Clk may be filtered by the synchronizer; no further debounce.

Test Plan (bench uses INHIBIT_CYCLES=10, TIMEOUT_CYCLES=200, device model clocks at 1 edge per 40 cycles):
- Enable command:
  - Stimulus: pulse start with iEnableMouse=1; device drives ack low.
  - Required: oPs2ClkLow=1 for exactly 10 cycles, then data low and clock released.
  - Bits sampled on device rising edges: 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - oDone pulse with oError=0; oBusy=0 one cycle later.
- Disable command: iEnableMouse=0 -> bits 1,0,1,0,1,1,1,1, parity 1, stop 1; ack -> oDone, oError=0.
- No ack: device leaves data high at edge #11 -> oDone pulse with oError=1; both lines released; oError stays 1 in IDLE.
- Silent device: no clock edges after release -> oDone with oError=1 exactly 200 cycles after entering START. Also stall after edge #5 for 200 cycles -> same.
- Busy/reset:
  - Start pulses during DATA with iEnableMouse toggled -> no effect on the transmitted byte.
  - iResetn low mid-DATA -> oPs2ClkLow=0, oPs2DatLow=0, oBusy=0 immediately (same cycle, asynchronous).
  - Next start after reset sends a full frame.
